// File: rtl/mux_nto1_hs_pkg.sv
// Shared constants and types for the N-to-1 handshake selector (mux_nto1_hs).
package mux_nto1_hs_pkg;

  localparam int   INTERNAL_BITS  = 32;
  localparam logic MUX_MODE_FIXED = 1'b0;
  localparam logic MUX_MODE_RR    = 1'b1;

  typedef enum logic {
    OBUF_EMPTY = 1'b0,
    OBUF_FULL  = 1'b1
  } obuf_state_t;

  // Channel index increment with wrap back to 0 after n-1.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/mux_nto1_hs_if.sv
// Bus bundle for mux_nto1_hs: per-channel input lanes, select/mode, registered output.
// Handshake: a beat moves on a lane when its valid and ready are both high at a rising
// edge; valid never waits on ready, and ready may depend combinationally on valid.
interface mux_nto1_hs_if #(
  parameter int DATA_W = mux_nto1_hs_pkg::INTERNAL_BITS,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) ();

  logic [NUM_CH*DATA_W-1:0]      in_data;
  logic [NUM_CH-1:0]             in_valid;
  logic [NUM_CH-1:0]             in_ready;
  logic [SEL_W-1:0]              sel;
  logic                          mode;
  logic [DATA_W-1:0]             out_data;
  logic [SEL_W-1:0]              out_ch;
  logic                          out_valid;
  logic                          out_ready;
  mux_nto1_hs_pkg::obuf_state_t  dbg_state;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_ch, out_valid, dbg_state
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_ch, out_valid, dbg_state
  );

endinterface

// File: rtl/mux_nto1_hs_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping to 0.
module mux_nto1_hs_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  logic found;

  // Two ascending passes: channels >= ptr first, then the wrapped part below ptr.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_hs.sv
// mux_nto1_hs: N-to-1 selector with per-lane valid/ready and a one-deep registered output.
// Round-robin arbitration is built only when MUX_RR_EN is defined; otherwise fixed select only.
module mux_nto1_hs
  import mux_nto1_hs_pkg::*;
#(
  parameter int DATA_W = INTERNAL_BITS,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input logic          clk,
  input logic          rst_n,
  mux_nto1_hs_if.slave bus
);

  obuf_state_t       state_q, state_d;
  logic              load_en;
  logic              xfer;
  logic [NUM_CH-1:0] fixed_grant;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] in_ready_w;
  logic [SEL_W-1:0]  grant_idx;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] out_data_q;
  logic [SEL_W-1:0]  out_ch_q;

  // An out-of-range sel matches no channel and so grants nothing.
  always_comb begin
    fixed_grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(bus.sel) == i) fixed_grant[i] = bus.in_valid[i];
    end
  end

`ifdef MUX_RR_EN
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  rr_idx;
  logic [NUM_CH-1:0] rr_grant;
  logic              use_rr;

  mux_nto1_hs_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr_arbiter (
    .req       (bus.in_valid),
    .ptr       (rr_ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  assign use_rr    = (bus.mode == MUX_MODE_RR);
  assign grant     = use_rr ? rr_grant : fixed_grant;
  assign grant_idx = use_rr ? rr_idx : bus.sel;

  // Pointer follows every accepted beat, whichever mode granted it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= SEL_W'(wrap_inc(int'(grant_idx), NUM_CH));
    end
  end
`else
  logic unused_mode;

  assign unused_mode = bus.mode;
  assign grant       = fixed_grant;
  assign grant_idx   = bus.sel;
`endif

  assign load_en    = (state_q == OBUF_EMPTY) || bus.out_ready;
  assign in_ready_w = rst_n ? (grant & {NUM_CH{load_en}}) : '0;
  assign xfer       = |(bus.in_valid & in_ready_w);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) sel_data = bus.in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OBUF_EMPTY;
    else        state_q <= state_d;
  end

  // A load while draining keeps the register FULL with the new beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OBUF_EMPTY: if (xfer) state_d = OBUF_FULL;
      OBUF_FULL:  if (!xfer && bus.out_ready) state_d = OBUF_EMPTY;
      default:    state_d = OBUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_ch_q   <= '0;
    end else if (xfer) begin
      out_data_q <= sel_data;
      out_ch_q   <= grant_idx;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = (state_q == OBUF_FULL);
  assign bus.dbg_state = state_q;

endmodule
